fsk_tx_ctrl: RTL

Frame sequencer that drives the FSK modulator's Din and enable inputs. It accepts payload bytes from an upstream requester over a valid/ready stream. Each transmission is a frame: preamble, then sync word, then payload bits, then a silent gap. Every bit is held for exactly BIT_PERIOD clocks. The block sits directly upstream of fsk_modulation, with mod_din connected to Din and mod_enable connected to enable.

---
 rtl/fsk_ctrl_pkg.sv | 38 +++
 rtl/fsk_tx_ctrl_if.sv | 25 ++
 rtl/fsk_bit_timer.sv | 30 +++
 rtl/fsk_tx_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fsk_ctrl_pkg.sv
// fsk_tx_ctrl shared types and constants.
// Defines state_t, byte_t, sync and byte-slot sizes, plus byte_slot().
package fsk_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    DATA,
    GAP
  } state_t;

  typedef logic [7:0] byte_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;
  localparam int SYNC_LEN = 16;

`ifdef FSK_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 9;
`else
  localparam int BITS_PER_BYTE = 8;
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Byte slot left-aligned in 16 bits, MSB sent first.
  // With parity, the even-parity bit follows bit 0.
  function automatic logic [15:0] byte_slot(input byte_t d);
`ifdef FSK_TX_PARITY_EN
    return {d, ^d, 7'b0};
`else
    return {d, 8'b0};
`endif
  endfunction

endpackage

// File: rtl/fsk_tx_ctrl_if.sv
// Payload byte stream into fsk_tx_ctrl.
// s_valid/s_data/s_last from source, s_ready back.
interface fsk_tx_ctrl_if;
  import fsk_ctrl_pkg::*;

  logic  s_valid;
  byte_t s_data;
  logic  s_last;
  logic  s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/fsk_bit_timer.sv
// Bit period counter: 0..BIT_PERIOD-1 while run.
// Ports: clk, reset, clear, run in; bit_end out.
module fsk_bit_timer #(
  parameter int BIT_PERIOD = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int CW = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign bit_end = run && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsk_tx_ctrl.sv
// FSK frame sequencer: preamble, sync, payload, gap.
// Ports: clk, reset, s (stream slave), mod_din,
// mod_enable, busy, bit_strobe, underrun.
// Option: FSK_TX_PARITY_EN adds even parity per byte.
module fsk_tx_ctrl
  import fsk_ctrl_pkg::*;
#(
  parameter int          BIT_PERIOD    = 512,
  parameter int          PREAMBLE_BITS = 16,
  parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int          GAP_BITS      = 4
) (
  input  logic         clk,
  input  logic         reset,
  fsk_tx_ctrl_if.slave s,
  output logic         mod_din,
  output logic         mod_enable,
  output logic         busy,
  output logic         bit_strobe,
  output logic         underrun
);

  localparam int IMAX = max_int(
    max_int(PREAMBLE_BITS, SYNC_LEN),
    max_int(GAP_BITS, BITS_PER_BYTE));
  localparam int IW = $clog2(IMAX);

  localparam logic [IW-1:0] PRE_LAST  = IW'(PREAMBLE_BITS - 1);
  localparam logic [IW-1:0] SYNC_LAST = IW'(SYNC_LEN - 1);
  localparam logic [IW-1:0] BYTE_LAST = IW'(BITS_PER_BYTE - 1);
  localparam logic [IW-1:0] GAP_LAST  = IW'(GAP_BITS - 1);

  state_t        st;
  logic [IW-1:0] idx;
  logic [15:0]   sh;
  logic          last_q;
  logic          bit_end;
  logic          load;
  logic [15:0]   slot;

  fsk_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (st == IDLE),
    .run    (st != IDLE),
    .bit_end(bit_end)
  );

  // Next byte is needed after sync and after
  // every byte that did not carry s_last.
  always_comb begin
    load = 1'b0;
    unique case (1'b1)
      (st == SYNC):
        load = bit_end && (idx == SYNC_LAST);
      (st == DATA):
        load = bit_end && (idx == BYTE_LAST)
               && !last_q;
      default:
        load = 1'b0;
    endcase
  end

  assign slot       = byte_slot(s.s_data);
  assign s.s_ready  = load;
  assign underrun   = load && !s.s_valid;
  assign bit_strobe = bit_end;
  assign busy       = (st != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      idx        <= '0;
      sh         <= '0;
      last_q     <= 1'b0;
      mod_din    <= 1'b0;
      mod_enable <= 1'b0;
    end else if (load) begin
      idx <= '0;
      if (s.s_valid) begin
        st      <= DATA;
        last_q  <= s.s_last;
        mod_din <= slot[15];
        sh      <= {slot[14:0], 1'b0};
      end else begin
        st         <= GAP;
        mod_din    <= 1'b0;
        mod_enable <= 1'b0;
      end
    end else begin
      unique case (st)
        IDLE: begin
          if (s.s_valid) begin
            st         <= PREAMBLE;
            idx        <= '0;
            mod_enable <= 1'b1;
            mod_din    <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (bit_end) begin
            if (idx == PRE_LAST) begin
              st      <= SYNC;
              idx     <= '0;
              mod_din <= SYNC_WORD[15];
              sh      <= {SYNC_WORD[14:0], 1'b0};
            end else begin
              idx     <= idx + 1'b1;
              mod_din <= ~mod_din;
            end
          end
        end
        SYNC, DATA: begin
          if (bit_end) begin
            // Only a last-tagged byte reaches here
            // at its final bit; others load above.
            if (st == DATA && idx == BYTE_LAST) begin
              st         <= GAP;
              idx        <= '0;
              mod_din    <= 1'b0;
              mod_enable <= 1'b0;
            end else begin
              idx     <= idx + 1'b1;
              mod_din <= sh[15];
              sh      <= {sh[14:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (bit_end) begin
            if (idx == GAP_LAST) begin
              st  <= IDLE;
              idx <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
